// File: rtl/edge_frame_ctrl.sv
// edge_frame_ctrl: frame sequencer and result checker around a Sobel edge stage.
//
// Builds valid/sop/eop framing for a raw binary raster that only carries a
// frame-start strobe, then tracks the Sobel result stream, masks the invalid
// border pixels, and reports frame completion and protocol errors.
//
// Optional feature: define BORDER_MASK_EN to force border pixels (orow<2 or
// ocol<2) to zero on dout. Without it, dout is the registered sob_dout.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   en                                 level, enables frame acceptance
//   in_sof, in_din, in_vld             raw pixel stream (sof on first pixel)
//   sob_din, sob_din_vld/sop/eop       registered stream to the Sobel engine
//   sob_dout, sob_dout_vld/sop/eop     result stream from the Sobel engine
//   dout, dout_vld/sop/eop             registered, masked edge stream
//   busy                               high while a frame is in RUN or DRAIN
//   frame_done                         one-cycle pulse per clean frame
//   err                                sticky error, cleared by en low in IDLE
//   frame_cnt                          clean frame count, wraps at 0xFFFF
module edge_frame_ctrl #(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int CNT_W    = 11,
    parameter int DRAIN_TO = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        in_sof,
    input  logic        in_din,
    input  logic        in_vld,
    output logic        sob_din,
    output logic        sob_din_vld,
    output logic        sob_din_sop,
    output logic        sob_din_eop,
    input  logic        sob_dout,
    input  logic        sob_dout_vld,
    input  logic        sob_dout_sop,
    input  logic        sob_dout_eop,
    output logic        dout,
    output logic        dout_vld,
    output logic        dout_sop,
    output logic        dout_eop,
    output logic        busy,
    output logic        frame_done,
    output logic        err,
    output logic [15:0] frame_cnt
);
    localparam int DW = $clog2(DRAIN_TO + 1);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TO);

    logic [1:0]       state;
    logic [CNT_W-1:0] col, row, ocol, orow, pcol, prow;
    logic [DW-1:0]    drain, drain_nxt;
    logic             start, fwd, in_last, at_last, eop_ok, done, timeout;
    logic             sof_err, out_err, pix;

    // pcol/prow is the position of the result pixel on the bus this cycle;
    // ocol/orow hold the position expected next, and sop restarts at 0,0.
    always_comb begin
        start     = state == S_WAIT && en && in_vld && in_sof;
        fwd       = start || (state == S_RUN && in_vld);
        in_last   = state == S_RUN && row == ROW_LAST && col == COL_LAST;
        pcol      = sob_dout_sop ? '0 : ocol;
        prow      = sob_dout_sop ? '0 : orow;
        at_last   = pcol == COL_LAST && prow == ROW_LAST;
        eop_ok    = sob_dout_eop && sob_dout_vld && at_last;
        drain_nxt = drain + 1'b1;
        done      = state == S_DRAIN && eop_ok;
        // a clean eop in the expiry cycle takes priority over the timeout
        timeout   = state == S_DRAIN && !eop_ok && drain_nxt == DRAIN_LAST;
        sof_err   = state == S_RUN && in_vld && in_sof;
        out_err   = (sob_dout_sop && !sob_dout_vld) || (sob_dout_eop && !(sob_dout_vld && at_last));
`ifdef BORDER_MASK_EN
        // the window centre lags one line and one pixel, so the first two
        // rows and columns carry no valid gradient
        pix       = (prow < CNT_W'(2) || pcol < CNT_W'(2)) ? 1'b0 : sob_dout;
`else
        pix       = sob_dout;
`endif
    end

    assign busy = state == S_RUN || state == S_DRAIN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            col   <= '0;
            row   <= '0;
            drain <= '0;
        end else begin
            case (state)
                S_IDLE: state <= en ? S_WAIT : S_IDLE;
                S_WAIT: begin
                    if (!en) begin
                        state <= S_IDLE;
                    end else if (start) begin
                        state <= S_RUN;
                        col   <= CNT_W'(1);
                        row   <= '0;
                    end
                end
                S_RUN: begin
                    if (in_vld) begin
                        if (in_last) begin
                            state <= S_DRAIN;
                            col   <= '0;
                            row   <= '0;
                            drain <= '0;
                        end else if (col == COL_LAST) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (done)
                        state <= en ? S_WAIT : S_IDLE;
                    else if (timeout)
                        state <= S_IDLE;
                    else
                        drain <= drain_nxt;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sob_din     <= 1'b0;
            sob_din_vld <= 1'b0;
            sob_din_sop <= 1'b0;
            sob_din_eop <= 1'b0;
        end else begin
            sob_din     <= fwd && in_din;
            sob_din_vld <= fwd;
            sob_din_sop <= start;
            sob_din_eop <= fwd && in_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ocol <= '0;
            orow <= '0;
        end else if (sob_dout_vld) begin
            ocol <= pcol == COL_LAST ? '0 : pcol + 1'b1;
            orow <= pcol != COL_LAST ? prow : prow == ROW_LAST ? '0 : prow + 1'b1;
        end else if (sob_dout_sop) begin
            ocol <= '0;
            orow <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout     <= 1'b0;
            dout_vld <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
        end else begin
            dout     <= pix;
            dout_vld <= sob_dout_vld;
            dout_sop <= sob_dout_sop;
            dout_eop <= sob_dout_eop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            err        <= 1'b0;
        end else begin
            frame_done <= done;
            frame_cnt  <= frame_cnt + {15'd0, done};
            err        <= (state == S_IDLE && !en) ? 1'b0 : (err || sof_err || out_err || timeout);
        end
    end
endmodule

// File: tb/tb_edge_frame_ctrl.sv
// tb_edge_frame_ctrl: directed frame scenarios for edge_frame_ctrl on an 8x4 image.
module tb_edge_frame_ctrl;
    logic clk = 1'b0;
    logic rst_n, en, in_sof, in_din, in_vld;
    logic sob_din, sob_din_vld, sob_din_sop, sob_din_eop;
    logic sob_dout, sob_dout_vld, sob_dout_sop, sob_dout_eop;
    logic dout, dout_vld, dout_sop, dout_eop, busy, frame_done, err;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    edge_frame_ctrl #(.IMG_W(8), .IMG_H(4), .CNT_W(4), .DRAIN_TO(15)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_sof(in_sof), .in_din(in_din), .in_vld(in_vld),
        .sob_din(sob_din), .sob_din_vld(sob_din_vld), .sob_din_sop(sob_din_sop), .sob_din_eop(sob_din_eop),
        .sob_dout(sob_dout), .sob_dout_vld(sob_dout_vld), .sob_dout_sop(sob_dout_sop), .sob_dout_eop(sob_dout_eop),
        .dout(dout), .dout_vld(dout_vld), .dout_sop(dout_sop), .dout_eop(dout_eop),
        .busy(busy), .frame_done(frame_done), .err(err), .frame_cnt(frame_cnt)
    );

    bit img [32];
    int lat = 4;
    bit hold = 1'b0;
    logic [3:0] pipe [16];
    int mpos;

    function automatic int px(int r, int c);
        return (r < 0 || r > 3 || c < 0 || c > 7) ? 0 : int'(img[r*8+c]);
    endfunction

    function automatic logic sob(int cr, int cc);
        int gx, gy;
        gx = px(cr-1, cc+1) + 2*px(cr, cc+1) + px(cr+1, cc+1) - px(cr-1, cc-1) - 2*px(cr, cc-1) - px(cr+1, cc-1);
        gy = px(cr+1, cc-1) + 2*px(cr+1, cc) + px(cr+1, cc+1) - px(cr-1, cc-1) - 2*px(cr-1, cc) - px(cr-1, cc+1);
        return gx != 0 || gy != 0;
    endfunction

    // Sobel engine stand-in: zero-padded 3x3 gradient centred one line and
    // one pixel behind the current position, delayed by 'lat' cycles.
    always @(posedge clk or negedge rst_n) begin
        int p;
        logic [3:0] e;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) pipe[i] <= 4'b0;
            mpos <= 0;
        end else begin
            p = sob_din_sop ? 0 : mpos;
            e = sob_din_vld ? {1'b1, sob_din_sop, sob_din_eop && !hold, sob(p/8 - 1, p%8 - 1)} : 4'b0;
            pipe[0] <= e;
            for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
            if (sob_din_vld) mpos <= p + 1;
        end
    end
    assign {sob_dout_vld, sob_dout_sop, sob_dout_eop, sob_dout} = pipe[lat-1];

    int din_cnt = 0, din_sop_pos = -1, din_eop_pos = -1, done_cnt = 0, noeop_cnt = 0, oidx = 0;
    logic dout_arr [32];

    always @(negedge clk) begin
        int idx;
        if (sob_din_vld) begin
            if (sob_din_sop) din_sop_pos = din_cnt;
            if (sob_din_eop) din_eop_pos = din_cnt;
            din_cnt = din_cnt + 1;
        end
        if (frame_done) done_cnt = done_cnt + 1;
        if (frame_done && !dout_eop) noeop_cnt = noeop_cnt + 1;
        if (dout_vld) begin
            idx = dout_sop ? 0 : oidx;
            if (idx < 32) dout_arr[idx] = dout;
            oidx = idx + 1;
        end
    end

    typedef struct {
        int pat;
        int pre;
        int sof_at;
        int lt;
        bit hd;
        int exp_done;
        bit exp_err;
    } vec_t;
    vec_t tv [7];

    int n_cmp = 0, n_bad = 0, exp_cnt = 0;
    int b_din, b_done, b_ne;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit pix(int pat, int k);
        return pat == 0 ? 1'b1 : (k % 8 >= 4);
    endfunction

    function automatic logic exp_px(int pat, int r, int c);
        if (r >= 2 && c >= 2) return pat == 1 && (c == 4 || c == 5);
`ifdef BORDER_MASK_EN
        return 1'b0;
`else
        return sob(r - 1, c - 1);
`endif
    endfunction

    function automatic int all_outs();
        return int'({sob_din, sob_din_vld, sob_din_sop, sob_din_eop, dout, dout_vld, dout_sop, dout_eop,
                     busy, frame_done, err, 4'b0, frame_cnt});
    endfunction

    task automatic load_img(int pat);
        for (int k = 0; k < 32; k++) img[k] = pix(pat, k);
    endtask

    task automatic send_frame(int pat, int pre, int sof_at);
        for (int k = 0; k < pre; k++) begin
            in_vld = 1'b1; in_sof = 1'b0; in_din = 1'b1;
            step();
        end
        for (int k = 0; k < 32; k++) begin
            in_vld = 1'b1; in_sof = (k == 0) || (k == sof_at); in_din = pix(pat, k);
            step();
        end
        in_vld = 1'b0; in_sof = 1'b0; in_din = 1'b0;
    endtask

    task automatic clear_err(bit prev);
        en = 1'b0;
        step();
        chk("err_sticky", int'(err), int'(prev));
        step();
        chk("err_clear", int'(err), 0);
    endtask

    initial begin
        tv[0] = '{0, 0, -1,  4, 1'b0, 1, 1'b0};
        tv[1] = '{1, 0, -1,  4, 1'b0, 1, 1'b0};
        tv[2] = '{0, 5, -1,  4, 1'b0, 1, 1'b0};
        tv[3] = '{0, 0,  9,  4, 1'b0, 1, 1'b1};
        tv[4] = '{0, 0, -1,  4, 1'b1, 0, 1'b1};
        tv[5] = '{1, 0, -1, 14, 1'b0, 1, 1'b0};
        tv[6] = '{0, 0, -1, 15, 1'b0, 0, 1'b1};
        rst_n = 1'b0; en = 1'b0; in_sof = 1'b0; in_din = 1'b0; in_vld = 1'b0;
        repeat (3) step();
        chk("reset_outputs", all_outs(), 0);
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 7; i++) begin
            if (i > 0) clear_err(tv[i-1].exp_err);
            en = 1'b1; lat = tv[i].lt; hold = tv[i].hd;
            load_img(tv[i].pat);
            step();
            b_din = din_cnt; b_done = done_cnt; b_ne = noeop_cnt;
            send_frame(tv[i].pat, tv[i].pre, tv[i].sof_at);
            if (tv[i].hd) begin
                repeat (14) step();
                chk($sformatf("s%0d_err_before_timeout", i), int'(err), 0);
                step();
                chk($sformatf("s%0d_err_at_timeout", i), int'(err), 1);
                chk($sformatf("s%0d_busy_at_timeout", i), int'(busy), 0);
                repeat (15) step();
            end else begin
                repeat (30) step();
            end
            exp_cnt += tv[i].exp_done;
            chk($sformatf("s%0d_din_count", i), din_cnt - b_din, 32);
            chk($sformatf("s%0d_sop_pos", i), din_sop_pos - b_din, 0);
            chk($sformatf("s%0d_eop_pos", i), din_eop_pos - b_din, 31);
            chk($sformatf("s%0d_done_pulses", i), done_cnt - b_done, tv[i].exp_done);
            chk($sformatf("s%0d_done_without_eop", i), noeop_cnt - b_ne, 0);
            chk($sformatf("s%0d_frame_cnt", i), int'(frame_cnt), exp_cnt);
            chk($sformatf("s%0d_err", i), int'(err), int'(tv[i].exp_err));
            chk($sformatf("s%0d_busy", i), int'(busy), 0);
            for (int k = 0; k < 32; k++)
                chk($sformatf("s%0d_dout_r%0d_c%0d", i, k/8, k%8), int'(dout_arr[k]), int'(exp_px(tv[i].pat, k/8, k%8)));
        end

        // reset in the middle of a frame
        clear_err(tv[6].exp_err);
        en = 1'b1; lat = 4; hold = 1'b0;
        load_img(0);
        step();
        for (int k = 0; k < 17; k++) begin
            in_vld = 1'b1; in_sof = (k == 0); in_din = 1'b1;
            step();
        end
        chk("busy_mid_frame", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("outputs_in_reset", all_outs(), 0);
        step();
        step();
        rst_n = 1'b1;
        b_din = din_cnt;
        for (int k = 17; k < 32; k++) begin
            in_vld = 1'b1; in_sof = 1'b0; in_din = 1'b1;
            step();
        end
        in_vld = 1'b0;
        step();
        chk("no_forward_without_sof", din_cnt - b_din, 0);
        repeat (20) step();
        b_done = done_cnt;
        send_frame(0, 0, -1);
        repeat (30) step();
        chk("post_reset_done", done_cnt - b_done, 1);
        chk("post_reset_frame_cnt", int'(frame_cnt), 1);
        chk("post_reset_err", int'(err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/edge_frame_ctrl.md
# edge_frame_ctrl

Frame sequencer wrapped around the Sobel edge stage. It takes a raw raster stream of binary pixels with only a frame-start strobe, and counts columns and rows to generate the valid, start-of-packet and end-of-packet controls the Sobel engine needs. It then checks and counts the Sobel result stream, masks the invalid border pixels and reports frame completion and errors. It sits between the binarisation stage and the display/VGA writer.

## Interface
- IMG_W, 640: active pixels per line (≥3)
- IMG_H, 480: lines per frame (≥3)
- CNT_W, 11: column/row counter width; 2^CNT_W > max(IMG_W, IMG_H)
- DRAIN_TO, 15: maximum cycles from last input pixel to Sobel end-of-packet

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  level; enables frame acceptance
- in_sof  in  1  pulse, coincident with the first pixel of a frame
- in_din  in  1  binary pixel
- in_vld  in  1  pixel valid
- sob_din, sob_din_vld, sob_din_sop, sob_din_eop  out  1 each  stream to Sobel engine
- sob_dout, sob_dout_vld, sob_dout_sop, sob_dout_eop  in  1 each  stream from Sobel engine
- dout, dout_vld, dout_sop, dout_eop  out  1 each  masked edge stream
- busy  out  1  high in RUN or DRAIN
- frame_done  out  1  one-cycle pulse when a frame completes cleanly
- err  out  1  sticky; cleared only by reset or by en low in IDLE
- frame_cnt  out  16  count of clean frames, wraps at 0xFFFF

## Operation
- FSM states: IDLE, WAIT_SOF, RUN, DRAIN.
- IDLE: when en=1, go to WAIT_SOF. When en=0, clear err.
- WAIT_SOF: in_vld pixels without in_sof are dropped. in_sof & in_vld forwards the pixel with sob_din_sop=1, sets col=1, row=0 and enters RUN. en=0 returns to IDLE.
- RUN:
  - Each in_vld forwards the pixel and increments col. At col=IMG_W-1, col wraps to 0 and row increments.
  - The pixel at row=IMG_H-1, col=IMG_W-1 is sent with sob_din_eop=1, and the FSM goes to DRAIN.
  - en is ignored in RUN; a frame always completes.
  - in_sof in RUN sets err. That pixel is forwarded as an ordinary pixel and counting continues.
- DRAIN:
  - A drain counter starts at 0 and increments each cycle.
  - sob_dout_eop seen with the output counter at the last pixel: pulse frame_done, increment frame_cnt, then go to WAIT_SOF if en=1, else IDLE.
  - Drain counter reaching DRAIN_TO without eop: set err, return to IDLE.
- Output side, independent of the FSM:
  - ocol/orow count sob_dout_vld and are reset to 0 by sob_dout_sop.
  - sob_dout_sop with sob_dout_vld=0, or sob_dout_eop at a position other than the last pixel, sets err.
- Masking: the Sobel window centre lags by one line and one pixel, so the pixel at orow<2 or ocol<2 is forced to dout=0.

## Timing
- All outputs are zero after reset; the FSM resets to IDLE and all counters to 0.
- Input path: sob_din* are registered, 1 cycle after in_*.
- Output path: dout* are registered, 1 cycle after sob_dout*.
- End-to-end latency in_din→dout is 1 + Sobel latency (4) + 1 = 6 cycles.
- frame_done fires in the cycle after sob_dout_eop is sampled. dout_eop is asserted in that same cycle.
- Simultaneous sob_dout_eop and drain-counter expiry: eop wins, and the frame is clean.
- Reset asserted mid-frame: every output is immediately 0. The next frame requires a new in_sof.
- Counters never exceed IMG_W-1 / IMG_H-1.

## Configuration
- BORDER_MASK_EN defined: border masking is applied as described in Operation.
- BORDER_MASK_EN undefined: dout equals registered sob_dout. The ocol/orow counters remain, because error checking still uses them.

## Test plan
- IMG_W=8, IMG_H=4, en=1, one full frame of all-ones with in_sof on the first pixel:
  - sob_din_sop on the 1st forwarded pixel and sob_din_eop on the 32nd.
  - frame_done pulses once and frame_cnt=1.
  - With BORDER_MASK_EN, dout=0 for every pixel.
- Vertical edge (cols 0–3 = 0, cols 4–7 = 1), 8×4 frame: dout=1 only at orow≥2 with ocol in 4..5 (ocol 5 only if the centre lag places the edge there); all orow<2 pixels are 0.
- Pixels before in_sof in WAIT_SOF: no sob_din_vld until the in_sof pixel arrives.
- in_sof asserted at pixel 10 of RUN: err=1, the frame still ends with eop at pixel 32, and err stays set until en=0 in IDLE.
- Sobel model withholding eop: 15 cycles after the last input, err=1, FSM in IDLE, frame_cnt unchanged.
- rst_n pulsed low at pixel 17:
  - All outputs are 0 and busy=0.
  - A subsequent clean frame gives frame_cnt=1.
